// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data memory responder.
//   state_t      FSM encoding (IDLE=0, WAIT=1, RESP=2)
//   DMEM_DATA_W  default data word width
//   DMEM_ADDR_W  default word-address width
//   BYTE_W       byte-lane width used by the write mask
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_ADDR_W = 8;
  localparam int BYTE_W      = 8;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: synchronous single-port word memory.
//   clk    clock (rising edge)
//   en     access strobe; one read or write per strobed edge
//   we     1 = write, 0 = read
//   addr   word address, must be < DEPTH when en is high
//   wdata  write data
//   wmask  per-byte write mask (bit i gates byte lane i)
//   rdata  registered read data; holds its value until the next read
// Contents are not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/BYTE_W-1:0] wmask,
  output logic [DATA_W-1:0]        rdata
);

  localparam int BE_W = DATA_W / BYTE_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (wmask[i]) begin
            mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
          end
        end
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the load/store bus. Accepts one
// word-addressed read/write at a time, optionally delays it by WAIT_STATES
// cycles, performs it on dmem_array and returns a single response.
//   clk, rst                 clock and synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_we/addr/wdata/be     request payload (be honoured only when the
//                            DMEM_BYTE_EN_EN macro is defined)
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata                read data, 0 for writes and errors
//   rsp_err                  address was >= DEPTH
// Optional feature macro: DMEM_BYTE_EN_EN (byte-masked writes).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; req_ready=1
// WAIT    | request latched, counting down wait states; req_ready=0
// RESP    | response presented; req_ready follows rsp_ready
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = DMEM_DATA_W,
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic [DATA_W/BYTE_W-1:0] req_be,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err
);

  localparam int BE_W = DATA_W / BYTE_W;
  // One extra bit so DEPTH == 2**ADDR_W compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_rd_q, rsp_rd_d;

  logic              req_fire;
  logic              acc_start;
  logic              use_latched;
  logic              acc_we;
  logic              acc_oor;
  logic              arr_en;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic [BE_W-1:0]   wmask;
  logic [DATA_W-1:0] arr_rdata;

  assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
  assign req_fire  = req_valid && req_ready;

  // A zero-wait access happens on the accept edge straight from the bus;
  // a delayed one uses the copy latched at accept time.
  assign use_latched = (state_q == ST_WAIT);
  assign acc_we      = use_latched ? we_q    : req_we;
  assign acc_addr    = use_latched ? addr_q  : req_addr;
  assign acc_wdata   = use_latched ? wdata_q : req_wdata;
  assign acc_be      = use_latched ? be_q    : req_be;
  assign acc_oor     = {1'b0, acc_addr} >= DEPTH_L;

`ifdef DMEM_BYTE_EN_EN
  assign wmask = acc_be;
`else
  logic unused_be;
  assign wmask     = '1;
  assign unused_be = ^acc_be;
`endif

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rd_d    = rsp_rd_q;
    acc_start   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        if ((state_q == ST_RESP) && rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rd_d    = 1'b0;
        end
        if (req_fire) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_STATES == 0) begin
            acc_start = 1'b1;
            state_d   = ST_RESP;
          end else begin
            wait_cnt_d = 4'(WAIT_STATES - 1);
            state_d    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          acc_start = 1'b1;
          state_d   = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (acc_start) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = acc_oor;
      rsp_rd_d    = !acc_we && !acc_oor;
    end
  end

  // Reset also blocks the array so a write still pending in WAIT is dropped.
  assign arr_en = acc_start && !acc_oor && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rd_q    <= rsp_rd_d;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (acc_we),
    .addr  (acc_addr),
    .wdata (acc_wdata),
    .wmask (wmask),
    .rdata (arr_rdata)
  );

  // The array read register only moves on a read, so gating it keeps
  // rsp_rdata stable for the whole RESP phase.
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rd_q ? arr_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic [1:0]  rst;
  logic [1:0]  req_valid, req_ready, req_we;
  logic [1:0]  rsp_valid, rsp_ready, rsp_err;
  logic [7:0]  req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic [31:0] rsp_rdata [2];

  exp_t q0[$];
  exp_t q1[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_acc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dut0: no wait states, 200 implemented words (out-of-range above 199)
  data_mem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  // dut1: three wait states, full 256-word array
  data_mem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic do_req(input int d, input logic we, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic push, input logic [31:0] er, input logic ee);
    exp_t e;
    int   n;
    e.rdata = er;
    e.err   = ee;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    req_valid[d] = 1'b1;
    if (push) begin
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[d] && n < 100);
    if (!req_ready[d]) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout dut%0d addr 0x%02h: req_ready stayed 0, required 1", d, addr);
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
    req_valid[d] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc_t [4];
    logic [31:0] be_exp0, be_exp1;

    rst       = 2'b11;
    req_valid = 2'b00;
    req_we    = 2'b00;
    rsp_ready = 2'b11;
    for (int d = 0; d < 2; d++) begin
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      req_be[d]    = '0;
    end

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          for (int d = 0; d < 2; d++) begin
            if (rsp_valid[d] && rsp_ready[d] && !rst[d]) begin
              if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp dut%0d: got rdata 0x%08h err %0b, required no response",
                         d, rsp_rdata[d], rsp_err[d]);
              end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check($sformatf("rsp_rdata dut%0d", d), rsp_rdata[d], e.rdata);
                check($sformatf("rsp_err dut%0d", d), 32'(rsp_err[d]), 32'(e.err));
              end
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst = 2'b00;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset req_ready dut%0d", d), 32'(req_ready[d]), 32'd1);
      check($sformatf("reset rsp_valid dut%0d", d), 32'(rsp_valid[d]), 32'd0);
      check($sformatf("reset rsp_rdata dut%0d", d), rsp_rdata[d], 32'd0);
      check($sformatf("reset rsp_err dut%0d", d), 32'(rsp_err[d]), 32'd0);
    end
    @(posedge clk);
    #1;

    // Write then read, one cycle latency each
    do_req(0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    check("zero_wait latency write", 32'(rsp_valid[0]), 32'd1);
    @(posedge clk);
    #1;
    do_req(0, 1'b0, 8'h10, 32'h0, 4'hF, 1'b1, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    check("zero_wait latency read", 32'(rsp_valid[0]), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back throughput and write-then-read ordering
    do_req(0, 1'b1, 8'h01, 32'h11111111, 4'hF, 1'b1, 32'h0, 1'b0);
    acc_t[0] = last_acc;
    do_req(0, 1'b1, 8'h02, 32'h22222222, 4'hF, 1'b1, 32'h0, 1'b0);
    acc_t[1] = last_acc;
    do_req(0, 1'b0, 8'h01, 32'h0, 4'hF, 1'b1, 32'h11111111, 1'b0);
    acc_t[2] = last_acc;
    do_req(0, 1'b0, 8'h02, 32'h0, 4'hF, 1'b1, 32'h22222222, 1'b0);
    acc_t[3] = last_acc;
    for (int i = 1; i < 4; i++)
      check($sformatf("throughput gap %0d", i), 32'(acc_t[i] - acc_t[i-1]), 32'd1);

    // Out of range on DEPTH=200, plus last valid word
    do_req(0, 1'b1, 8'd210, 32'h12345678, 4'hF, 1'b1, 32'h0, 1'b1);
    do_req(0, 1'b0, 8'd210, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1);
    do_req(0, 1'b1, 8'd199, 32'hCAFEF00D, 4'hF, 1'b1, 32'h0, 1'b0);
    do_req(0, 1'b0, 8'd199, 32'h0, 4'hF, 1'b1, 32'hCAFEF00D, 1'b0);
    do_req(0, 1'b0, 8'd255, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1);

    // Byte enables
`ifdef DMEM_BYTE_EN_EN
    be_exp0 = 32'hFF00FF00;
    be_exp1 = 32'hFF00FF00;
`else
    be_exp0 = 32'h00000000;
    be_exp1 = 32'h12345678;
`endif
    do_req(0, 1'b1, 8'h05, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0, 1'b0);
    do_req(0, 1'b1, 8'h05, 32'h00000000, 4'b0101, 1'b1, 32'h0, 1'b0);
    do_req(0, 1'b0, 8'h05, 32'h0, 4'hF, 1'b1, be_exp0, 1'b0);
    do_req(0, 1'b1, 8'h05, 32'h12345678, 4'b0000, 1'b1, 32'h0, 1'b0);
    do_req(0, 1'b0, 8'h05, 32'h0, 4'hF, 1'b1, be_exp1, 1'b0);

    // Backpressure: response held, queued request taken on the release edge
    @(posedge clk);
    #1;
    rsp_ready[0] = 1'b0;
    do_req(0, 1'b0, 8'h10, 32'h0, 4'hF, 1'b1, 32'hDEADBEEF, 1'b0);
    req_we[0]    = 1'b0;
    req_addr[0]  = 8'h01;
    req_valid[0] = 1'b1;
    q0.push_back('{rdata: 32'h11111111, err: 1'b0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall rsp_valid %0d", i), 32'(rsp_valid[0]), 32'd1);
      check($sformatf("stall rsp_rdata %0d", i), rsp_rdata[0], 32'hDEADBEEF);
      check($sformatf("stall rsp_err %0d", i), 32'(rsp_err[0]), 32'd0);
      check($sformatf("stall req_ready %0d", i), 32'(req_ready[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    check("release req_ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("queued rsp_valid", 32'(rsp_valid[0]), 32'd1);
    check("queued rsp_rdata", rsp_rdata[0], 32'h11111111);
    @(posedge clk);
    #1;

    // Wait states: accept at t, req_ready low t+1..t+3, response at t+4
    do_req(1, 1'b1, 8'h20, 32'h0BADCAFE, 4'hF, 1'b1, 32'h0, 1'b0);
    do_req(1, 1'b0, 8'h20, 32'h0, 4'hF, 1'b1, 32'h0BADCAFE, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("wait req_ready t+%0d", k), 32'(req_ready[1]), 32'd0);
      check($sformatf("wait rsp_valid t+%0d", k), 32'(rsp_valid[1]), 32'd0);
    end
    @(negedge clk);
    check("wait rsp_valid t+4", 32'(rsp_valid[1]), 32'd1);
    @(posedge clk);
    #1;

    // Reset during WAIT drops the pending write
    do_req(1, 1'b1, 8'h03, 32'h33333333, 4'hF, 1'b1, 32'h0, 1'b0);
    do_req(1, 1'b1, 8'h03, 32'hAAAA5555, 4'hF, 1'b0, 32'h0, 1'b0);
    rst[1] = 1'b1;
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    @(negedge clk);
    check("post_reset rsp_valid", 32'(rsp_valid[1]), 32'd0);
    check("post_reset req_ready", 32'(req_ready[1]), 32'd1);
    @(posedge clk);
    #1;
    do_req(1, 1'b0, 8'h03, 32'h0, 4'hF, 1'b1, 32'h33333333, 1'b0);

    for (int i = 0; i < 30 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    check("drain q0", 32'(q0.size()), 32'd0);
    check("drain q1", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
